// File: rtl/i2c_master_n.sv
// Purpose : I2C master running one addressed transaction of 0..MAX_BYTES bytes (read or write).
// Latency : (11 + 9*n) bit periods of 4*CLK_DIV clk from start acceptance to done; address NACK 11 periods.
// Backpr. : start is taken only while ready=1; a start while busy is dropped, no queueing.
//
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   start, rw, addr request strobe, direction (1 = read), 7-bit slave address
//   nbytes, wdata   byte count (clamped to MAX_BYTES), write payload (last byte in [7:0])
//   rdata           read payload, shifted in left so the last byte lands in [7:0]
//   ready, done     idle flag, one-cycle completion pulse
//   nack            sticky: last transaction ended on a slave NACK
//   sda, scl        open-drain data (drives 0 or z), push-pull clock
module i2c_master_n #(
  parameter int MAX_BYTES = 4,
  parameter int CLK_DIV   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             rw,
  input  logic [6:0]                       addr,
  input  logic [$clog2(MAX_BYTES+1)-1:0]   nbytes,
  input  logic [8*MAX_BYTES-1:0]           wdata,
  output logic [8*MAX_BYTES-1:0]           rdata,
  output logic                             ready,
  output logic                             done,
  output logic                             nack,
  inout  wire                              sda,
  output logic                             scl
);

  localparam int NBW = $clog2(MAX_BYTES+1);
  localparam int W   = 8*MAX_BYTES;
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     div_q;
  logic [1:0]        qtr_q;
  logic [2:0]        bit_q;
  logic [NBW-1:0]    byte_q;
  logic [NBW-1:0]    n_q;
  logic              rw_q;
  logic [7:0]        ash_q;
  logic [W-1:0]      wsh_q;
  logic              samp_q;
  logic [W-1:0]      rdata_q;
  logic              nack_q;
  logic              done_q;

  logic              qtick, bit_end, sample_en, multi_bit, state_end;
  logic              accept, last_byte;
  logic [NBW-1:0]    n_clamp;
  logic [W-1:0]      wload;
  logic              scl_c, sda_oe_c;

  assign qtick     = (div_q == DW'(CLK_DIV-1));
  assign bit_end   = qtick && (qtr_q == 2'd3);
  // Master samples SDA on the final clk of Q2, i.e. while SCL has been high for one quarter.
  assign sample_en = qtick && (qtr_q == 2'd2);
  assign multi_bit = (state_q == S_ADDR) || (state_q == S_WRITE) || (state_q == S_READ);
  assign state_end = bit_end && (!multi_bit || (bit_q == 3'd7));
  assign accept    = start && (state_q == S_IDLE);
  // byte_q counts completed data bytes, so in an ACK state it equals n on the final byte.
  assign last_byte = (byte_q == n_q);

  always_comb begin
    n_clamp = nbytes;
    if (int'(nbytes) > MAX_BYTES) n_clamp = NBW'(MAX_BYTES);
  end

  // Left-justify the payload so byte 0 (the most significant of the n used bytes) leaves first
  // and a plain MSB shift walks through all n bytes in order.
  always_comb begin
    wload = wdata << (8 * (MAX_BYTES - int'(n_clamp)));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_START;
      S_START:     if (state_end) state_d = S_ADDR;
      S_ADDR:      if (state_end) state_d = S_ADDR_ACK;
      S_ADDR_ACK:  if (state_end) begin
                     if (samp_q || (n_q == '0)) state_d = S_STOP;
                     else if (rw_q)             state_d = S_READ;
                     else                       state_d = S_WRITE;
                   end
      S_WRITE:     if (state_end) state_d = S_WRITE_ACK;
      S_WRITE_ACK: if (state_end) state_d = (samp_q || last_byte) ? S_STOP : S_WRITE;
      S_READ:      if (state_end) state_d = S_READ_ACK;
      S_READ_ACK:  if (state_end) state_d = last_byte ? S_STOP : S_READ;
      S_STOP:      if (state_end) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Bus outputs
  always_comb begin
    scl_c    = 1'b1;
    sda_oe_c = 1'b0;
    case (state_q)
      S_START:     sda_oe_c = qtr_q[1];
      S_ADDR:      begin scl_c = qtr_q[1]; sda_oe_c = ~ash_q[7]; end
      S_WRITE:     begin scl_c = qtr_q[1]; sda_oe_c = ~wsh_q[W-1]; end
      S_ADDR_ACK,
      S_WRITE_ACK,
      S_READ:      scl_c = qtr_q[1];
      S_READ_ACK:  begin scl_c = qtr_q[1]; sda_oe_c = ~last_byte; end
      // SCL rises with SDA low, then SDA is released while SCL is high.
      S_STOP:      begin scl_c = (qtr_q != 2'd0); sda_oe_c = ~qtr_q[1]; end
      default:     ;
    endcase
  end

  // Timing counters and datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      n_q     <= '0;
      rw_q    <= 1'b0;
      ash_q   <= '0;
      wsh_q   <= '0;
      samp_q  <= 1'b0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_STOP) && state_end;

      if ((state_q == S_IDLE) || state_end) begin
        div_q <= '0;
        qtr_q <= '0;
        bit_q <= '0;
      end else begin
        div_q <= qtick ? '0 : div_q + DW'(1);
        if (qtick)   qtr_q <= qtr_q + 2'd1;
        if (bit_end) bit_q <= bit_q + 3'd1;
      end

      if (accept) begin
        rw_q   <= rw;
        n_q    <= n_clamp;
        ash_q  <= {addr, rw};
        wsh_q  <= wload;
        nack_q <= 1'b0;
        byte_q <= '0;
        if (rw) rdata_q <= '0;
      end

      if (bit_end && (state_q == S_ADDR))  ash_q <= {ash_q[6:0], 1'b0};
      if (bit_end && (state_q == S_WRITE)) wsh_q <= {wsh_q[W-2:0], 1'b0};

      if (sample_en) samp_q <= sda;
      if (sample_en && (state_q == S_READ)) rdata_q <= {rdata_q[W-2:0], sda};

      if (state_end && ((state_q == S_WRITE) || (state_q == S_READ)))
        byte_q <= byte_q + NBW'(1);

      if (state_end && samp_q && ((state_q == S_ADDR_ACK) || (state_q == S_WRITE_ACK)))
        nack_q <= 1'b1;
    end
  end

  assign sda   = sda_oe_c ? 1'b0 : 1'bz;
  assign scl   = scl_c;
  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign nack  = nack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_i2c_master_n.sv
module tb_i2c_master_n;
  localparam int MB = 4;
  localparam int CD = 2;

  logic        clk = 1'b0;
  logic        rst, start, rw;
  logic [6:0]  addr;
  logic [2:0]  nbytes;
  logic [31:0] wdata, rdata;
  logic        ready, done, nack, scl;
  wire         sda;
  logic        slv_oe = 1'b0;

  pullup (sda);
  assign sda = slv_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_n #(.MAX_BYTES(MB), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .nbytes(nbytes),
    .wdata(wdata), .rdata(rdata), .ready(ready), .done(done), .nack(nack),
    .sda(sda), .scl(scl)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- bus monitor + slave ----------------
  bit          s_aack;
  int          s_nack_at;
  logic [31:0] s_rd;          // read byte k = s_rd[31-8k -: 8]
  int          s_rdn;
  int          cnt = 0, frame = 0, stop_cnt = 0;
  bit          rd_mode = 0, a_acked = 0;
  logic [7:0]  cur;
  logic [7:0]  obs_b[$];
  bit          obs_a[$];
  logic        pscl = 1'b1, psda = 1'b1, cs, ds;

  always @(negedge clk) begin
    cs = scl;
    ds = sda;
    if (pscl && cs && psda && !ds) begin
      obs_b.delete(); obs_a.delete();
      cnt = 0; frame = 0; rd_mode = 0; a_acked = 0; slv_oe = 1'b0;
    end else if (pscl && cs && !psda && ds) begin
      stop_cnt++;
      slv_oe = 1'b0;
    end else if (!pscl && cs) begin
      if (cnt < 8) cur = {cur[6:0], ds};
      else         obs_a.push_back(ds);
      cnt++;
      if (cnt == 8) begin
        obs_b.push_back(cur);
        if (frame == 0) rd_mode = cur[0];
      end
      if (cnt == 9) begin
        if (frame == 0) a_acked = !ds;
        cnt = 0;
        frame++;
      end
    end else if (pscl && !cs) begin
      slv_oe = 1'b0;
      if (cnt == 8) begin
        if (frame == 0)   slv_oe = s_aack;
        else if (!rd_mode) slv_oe = ((frame - 1) != s_nack_at);
      end else if (rd_mode && a_acked && frame >= 1 && (frame - 1) < s_rdn) begin
        slv_oe = !s_rd[31 - 8*(frame-1) - cnt];
      end
    end
    pscl = cs;
    psda = ds;
  end

  // ---------------- reference model ----------------
  logic [7:0]  exp_b[$];
  bit          exp_a[$];
  int          exp_lat;
  bit          exp_nack;
  logic [31:0] model_rdata = 32'h0;

  task automatic model_txn(input bit mrw, input bit [6:0] maddr, input int nb, input bit [31:0] mwd,
                           input bit aack, input int nak, input bit [31:0] mrd);
    int nn;
    int periods;
    logic [7:0] b;
    nn = (nb > MB) ? MB : nb;
    exp_b.delete(); exp_a.delete();
    exp_b.push_back({maddr, mrw});
    exp_nack = 0;
    if (mrw) model_rdata = 32'h0;
    if (!aack) begin
      exp_a.push_back(1'b1);
      exp_nack = 1;
      periods = 11;
    end else begin
      exp_a.push_back(1'b0);
      periods = 11 + 9*nn;
      for (int k = 0; k < nn; k++) begin
        if (mrw) begin
          b = 8'(mrd >> (24 - 8*k));
          exp_b.push_back(b);
          exp_a.push_back(k == nn - 1);
          model_rdata = (model_rdata << 8) | {24'h0, b};
        end else begin
          b = 8'(mwd >> (8*(nn - 1 - k)));
          exp_b.push_back(b);
          if (k == nak) begin
            exp_a.push_back(1'b1);
            exp_nack = 1;
            periods = 11 + 9*(k + 1);
            break;
          end
          exp_a.push_back(1'b0);
        end
      end
    end
    exp_lat = periods * 4 * CD;
  endtask

  task automatic run_txn(input bit trw, input bit [6:0] taddr, input bit [2:0] tnb, input bit [31:0] twd,
                         input bit taack, input int tnak, input bit [31:0] trd, input int busy_at,
                         output int lat);
    int  stops0;
    bit  bad;
    int  nb_ck;
    s_aack = taack; s_nack_at = tnak; s_rd = trd;
    s_rdn = (int'(tnb) > MB) ? MB : int'(tnb);
    model_txn(trw, taddr, int'(tnb), twd, taack, tnak, trd);
    stops0 = stop_cnt;
    rw = trw; addr = taddr; nbytes = tnb; wdata = twd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_ready", ready, 0);
    lat = 0; bad = 0;
    while (!done && lat < 3000) begin
      @(posedge clk); lat++; #1;
      if (!done && ready) bad = 1;
      if (lat == busy_at) begin start = 1'b1; rw = ~rw; addr = ~addr; end
      else start = 1'b0;
    end
    check("latency", lat, exp_lat);
    check("ready_low", bad, 0);
    check("nack", nack, exp_nack);
    check("rdata", rdata, model_rdata);
    check("stop_seen", stop_cnt, stops0 + 1);
    check("nbytes_on_bus", obs_b.size(), exp_b.size());
    nb_ck = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
    for (int i = 0; i < nb_ck; i++) check("bus_byte", obs_b[i], exp_b[i]);
    check("nacks_on_bus", obs_a.size(), exp_a.size());
    nb_ck = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < nb_ck; i++) check("ack_bit", obs_a[i], exp_a[i]);
  endtask

  typedef struct {
    bit        rw;
    bit [6:0]  addr;
    bit [2:0]  nb;
    bit [31:0] wdata;
    bit        aack;
    int        nak;
    bit [31:0] rd;
    int        exp_lat;
    bit        exp_nack;
    bit        chk_rd;
    bit [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w, st0;
    tbl[0]  = '{0, 7'h50, 3'd1, 32'h00000055, 0, -1, 32'h0,        88, 1, 0, 32'h0};
    tbl[1]  = '{0, 7'h50, 3'd2, 32'h0000aa55, 1, -1, 32'h0,       232, 0, 0, 32'h0};
    tbl[2]  = '{1, 7'h50, 3'd2, 32'h0,        1, -1, 32'hc33c0000, 232, 0, 1, 32'h0000c33c};
    tbl[3]  = '{0, 7'h50, 3'd0, 32'h12345678, 1, -1, 32'h0,        88, 0, 0, 32'h0};
    tbl[4]  = '{0, 7'h50, 3'd7, 32'h11223344, 1, -1, 32'h0,       376, 0, 0, 32'h0};
    tbl[5]  = '{0, 7'h50, 3'd3, 32'h00b0b1b2, 1,  1, 32'h0,       232, 1, 0, 32'h0};
    tbl[6]  = '{1, 7'h2a, 3'd4, 32'h0,        1, -1, 32'hdeadbeef, 376, 0, 1, 32'hdeadbeef};
    tbl[7]  = '{1, 7'h2a, 3'd1, 32'h0,        0, -1, 32'hffffffff,  88, 1, 1, 32'h0};
    tbl[8]  = '{1, 7'h13, 3'd7, 32'h0,        1, -1, 32'hcafef00d, 376, 0, 1, 32'hcafef00d};
    tbl[9]  = '{1, 7'h13, 3'd0, 32'h0,        1, -1, 32'h0,        88, 0, 1, 32'h0};
    tbl[10] = '{0, 7'h7f, 3'd4, 32'ha5a5a5a5, 1,  3, 32'h0,       376, 1, 0, 32'h0};
    tbl[11] = '{0, 7'h01, 3'd2, 32'h00001234, 1,  0, 32'h0,       160, 1, 0, 32'h0};

    rst = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; nbytes = '0; wdata = '0;
    s_aack = 0; s_nack_at = -1; s_rd = '0; s_rdn = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors, run back to back so every start lands in the done cycle.
    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].rw, tbl[i].addr, tbl[i].nb, tbl[i].wdata, tbl[i].aack, tbl[i].nak, tbl[i].rd, -1, lat);
      check("tbl_latency", lat, tbl[i].exp_lat);
      check("tbl_nack", nack, tbl[i].exp_nack);
      if (tbl[i].chk_rd) check("tbl_rdata", rdata, tbl[i].exp_rdata);
    end

    // start pulsed mid-transaction must be ignored
    run_txn(0, 7'h50, 3'd1, 32'h55, 0, -1, 32'h0, 20, lat);
    check("busy_latency", lat, 88);
    repeat (5) @(posedge clk);
    #1;
    check("busy_no_restart", ready, 1);

    // reset during WRITE bit 4: bus released on the next edge, no STOP
    rw = 1'b0; addr = 7'h50; nbytes = 3'd2; wdata = 32'h0000aa55;
    s_aack = 1; s_nack_at = -1; s_rdn = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    st0 = stop_cnt;
    w = 0;
    while (!(frame == 1 && cnt == 4 && scl == 1'b0) && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    check("rst_reach_bit4", (w < 1000), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_scl", scl, 1);
    check("abort_sda", sda, 1);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    rst = 1'b1;
    model_rdata = 32'h0;
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_stop", stop_cnt, st0);
    check("abort_idle", ready, 1);

    // Randomised transactions against the model
    for (int i = 0; i < 24; i++) begin
      bit r;
      int nak;
      r   = 1'($urandom_range(0, 1));
      nak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(r, 7'($urandom), 3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) != 0),
              nak, $urandom, -1, lat);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
